// File: rtl/mshr_table.sv
// Miss-status holding register table: tracks outstanding requests, allocates the
// lowest free slot, issues un-issued entries round-robin and supports indexed lookup.
module mshr_table #(
  parameter int unsigned ID_W   = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CPU_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  // allocate
  input  logic              add,
  input  logic [ADDR_W-1:0] add_addr,
  input  logic [DATA_W-1:0] add_data,
  input  logic              add_rw,
  input  logic              add_dirty,
  input  logic [CPU_W-1:0]  add_cpu_id,
  output logic              add_ack,
  output logic [ID_W-1:0]   add_id,
  // release
  input  logic              del,
  input  logic [ID_W-1:0]   del_id,
  // issue
  input  logic              read_next,
  output logic              rn_valid,
  output logic [ADDR_W-1:0] rn_addr,
  output logic [DATA_W-1:0] rn_data,
  output logic              rn_rw,
  output logic              rn_dirty,
  output logic [ID_W-1:0]   rn_mshr_id,
  // lookup
  input  logic              get,
  input  logic [ID_W-1:0]   get_id,
  output logic              get_valid,
  output logic              get_rw,
  output logic [DATA_W-1:0] get_data,
  output logic [ADDR_W-1:0] get_addr,
  output logic [CPU_W-1:0]  get_cpu_id,
  // occupancy
  output logic [ID_W:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int Depth = 2 ** ID_W;

  // Per-entry control state
  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] issued_q, issued_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  // Per-entry payload; only meaningful while the entry is valid, so left unreset
  logic [ADDR_W-1:0] addr_q  [Depth];
  logic [DATA_W-1:0] data_q  [Depth];
  logic              rw_q    [Depth];
  logic              dirty_q [Depth];
  logic [CPU_W-1:0]  cpu_q   [Depth];

  // Registered output state
  logic              rn_valid_q, rn_valid_d;
  logic [ADDR_W-1:0] rn_addr_q, rn_addr_d;
  logic [DATA_W-1:0] rn_data_q, rn_data_d;
  logic              rn_rw_q, rn_rw_d;
  logic              rn_dirty_q, rn_dirty_d;
  logic [ID_W-1:0]   rn_id_q, rn_id_d;

  logic              get_valid_q, get_valid_d;
  logic              get_rw_q, get_rw_d;
  logic [DATA_W-1:0] get_data_q, get_data_d;
  logic [ADDR_W-1:0] get_addr_q, get_addr_d;
  logic [CPU_W-1:0]  get_cpu_q, get_cpu_d;

  logic              free_found;
  logic [Depth-1:0]  del_mask;
  logic [Depth-1:0]  eligible;
  logic              rn_found;
  logic [ID_W-1:0]   rn_sel;
  logic [ID_W-1:0]   scan_idx;
  logic              do_issue;

  // Lowest-index free slot from the pre-edge valid vector
  always_comb begin
    free_found = 1'b0;
    add_id     = '0;
    for (int i = 0; i < Depth; i++) begin
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        add_id     = ID_W'(i);
      end
    end
  end

  // Occupancy count and flags derived from registered valid bits
  always_comb begin
    count = '0;
    for (int i = 0; i < Depth; i++) begin
      count = count + {{ID_W{1'b0}}, valid_q[i]};
    end
    full  = (count == (ID_W + 1)'(Depth));
    empty = (count == '0);
  end

  assign add_ack = add & enable & ~full;

  // One-hot of the entry being released; used to keep it out of the issue search
  always_comb begin
    del_mask = '0;
    if (del) begin
      del_mask[del_id] = 1'b1;
    end
  end

  assign eligible = valid_q & ~issued_q & ~del_mask;

  // Round-robin search for the next un-issued entry starting at rr_ptr
  always_comb begin
    rn_found = 1'b0;
    rn_sel   = rr_ptr_q;
    scan_idx = '0;
    for (int k = 0; k < Depth; k++) begin
      scan_idx = rr_ptr_q + ID_W'(k);
      if (!rn_found && eligible[scan_idx]) begin
        rn_found = 1'b1;
        rn_sel   = scan_idx;
      end
    end
  end

  assign do_issue = enable & read_next & rn_found;

  // Next-state for entry control bits and the round-robin pointer
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    rr_ptr_d = rr_ptr_q;
    if (enable) begin
      // A freed slot is never the allocated slot: add_id points at a slot already invalid
      if (del && valid_q[del_id]) begin
        valid_d[del_id]  = 1'b0;
        issued_d[del_id] = 1'b0;
      end
      if (add_ack) begin
        valid_d[add_id]  = 1'b1;
        issued_d[add_id] = 1'b0;
      end
      if (do_issue) begin
        issued_d[rn_sel] = 1'b1;
        rr_ptr_d         = rn_sel + ID_W'(1);
      end
    end
  end

  // Next-state for the issue and lookup output registers
  always_comb begin
    rn_valid_d  = rn_valid_q;
    rn_addr_d   = rn_addr_q;
    rn_data_d   = rn_data_q;
    rn_rw_d     = rn_rw_q;
    rn_dirty_d  = rn_dirty_q;
    rn_id_d     = rn_id_q;
    get_valid_d = get_valid_q;
    get_rw_d    = get_rw_q;
    get_data_d  = get_data_q;
    get_addr_d  = get_addr_q;
    get_cpu_d   = get_cpu_q;
    if (enable) begin
      rn_valid_d = do_issue;
      if (do_issue) begin
        rn_addr_d  = addr_q[rn_sel];
        rn_data_d  = data_q[rn_sel];
        rn_rw_d    = rw_q[rn_sel];
        rn_dirty_d = dirty_q[rn_sel];
        rn_id_d    = rn_sel;
      end
      get_valid_d = get & valid_q[get_id];
      if (get) begin
        get_rw_d   = rw_q[get_id];
        get_data_d = data_q[get_id];
        get_addr_d = addr_q[get_id];
        get_cpu_d  = cpu_q[get_id];
      end
    end
  end

  // Control state and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      issued_q    <= '0;
      rr_ptr_q    <= '0;
      rn_valid_q  <= 1'b0;
      rn_addr_q   <= '0;
      rn_data_q   <= '0;
      rn_rw_q     <= 1'b0;
      rn_dirty_q  <= 1'b0;
      rn_id_q     <= '0;
      get_valid_q <= 1'b0;
      get_rw_q    <= 1'b0;
      get_data_q  <= '0;
      get_addr_q  <= '0;
      get_cpu_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      issued_q    <= issued_d;
      rr_ptr_q    <= rr_ptr_d;
      rn_valid_q  <= rn_valid_d;
      rn_addr_q   <= rn_addr_d;
      rn_data_q   <= rn_data_d;
      rn_rw_q     <= rn_rw_d;
      rn_dirty_q  <= rn_dirty_d;
      rn_id_q     <= rn_id_d;
      get_valid_q <= get_valid_d;
      get_rw_q    <= get_rw_d;
      get_data_q  <= get_data_d;
      get_addr_q  <= get_addr_d;
      get_cpu_q   <= get_cpu_d;
    end
  end

  // Payload write on accepted allocation
  always_ff @(posedge clk) begin
    if (add_ack) begin
      addr_q[add_id]  <= add_addr;
      data_q[add_id]  <= add_data;
      rw_q[add_id]    <= add_rw;
      dirty_q[add_id] <= add_dirty;
      cpu_q[add_id]   <= add_cpu_id;
    end
  end

  assign rn_valid   = rn_valid_q;
  assign rn_addr    = rn_addr_q;
  assign rn_data    = rn_data_q;
  assign rn_rw      = rn_rw_q;
  assign rn_dirty   = rn_dirty_q;
  assign rn_mshr_id = rn_id_q;
  assign get_valid  = get_valid_q;
  assign get_rw     = get_rw_q;
  assign get_data   = get_data_q;
  assign get_addr   = get_addr_q;
  assign get_cpu_id = get_cpu_q;

endmodule
